dice_roll_ctrl: RTL and testbench

DICE_ROLL_CTRL -- requirements
Module: dice_roll_ctrl

---
 rtl/dice_roll_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_dice_roll_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roll_ctrl.sv
// ---------------------------------------------------------------------------
// dice_roll_ctrl
//
// Purpose:
//   Electronic dice controller. A raw push button is synchronized and
//   debounced. A press arms the roll, and releasing the button starts it.
//   An optional animation shows a series of random faces with frames that
//   get longer each time. The final face comes from rejection sampling of a
//   free-running 11-bit LFSR, so every face is equally likely.
//
// Configuration:
//   `DICE_ROLL_ANIM_EN  defined   -> ANIM state shows ANIM_STEPS frames,
//                                    then the final face is sampled.
//                       undefined -> a release goes straight to sampling;
//                                    dice_value keeps its old value until
//                                    the final face is accepted.
//
// Parameters:
//   DEBOUNCE_CYCLES  number of consecutive stable cycles needed to accept a
//                    change of the button level
//   ANIM_STEPS       number of animation frames
//   ANIM_BASE        base frame length; frame k lasts ANIM_BASE*(k+1) cycles
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous, active-high reset
//   trigger       raw asynchronous button, high = pressed
//   twty_mode     0 = d6, 1 = d20 (latched when a press is accepted)
//   dice_value    face being shown (animation frame or final roll)
//   result_valid  high while dice_value holds a final roll
//   busy          high from an accepted press until the result is final
// ---------------------------------------------------------------------------
module dice_roll_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ANIM_STEPS      = 8,
    parameter int ANIM_BASE       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger,
    input  logic       twty_mode,
    output logic [4:0] dice_value,
    output logic       result_valid,
    output logic       busy
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        ANIM,
        SAMPLE,
        SHOW
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_db_level;
    logic            r_db_prev;
    logic [DB_W-1:0] r_db_cnt;
    logic [10:0]     r_lfsr;
    logic            r_mode;
    logic [4:0]      r_dice_value;
    logic            r_result_valid;
    logic            r_busy;

    logic            w_rise;
    logic            w_fall;
    logic [2:0]      w_raw6;
    logic [4:0]      w_raw20;
    logic            w_accept;
    logic [4:0]      w_sample_face;

`ifdef DICE_ROLL_ANIM_EN
    logic [15:0]     r_frame;
    logic [15:0]     r_frame_cnt;
    logic [15:0]     w_frame_len;
    logic [2:0]      w_mod6;
    logic [4:0]      w_mod20;
    logic [4:0]      w_anim_face;
`endif

    // Two-flop synchronizer followed by a debouncer. The level only changes
    // once the synchronized input has disagreed with it for DEBOUNCE_CYCLES
    // cycles in a row; any cycle of agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_sync1   <= trigger;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db_level;
            if (r_sync2 != r_db_level) begin
                if (r_db_cnt == DB_LAST) begin
                    r_db_level <= r_sync2;
                    r_db_cnt   <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // One-cycle edge pulses of the debounced level.
    assign w_rise = r_db_level & ~r_db_prev;
    assign w_fall = ~r_db_level & r_db_prev;

    // The LFSR runs every cycle no matter what state the FSM is in, so the
    // time the user holds the button changes the result. Feedback taps 10/8
    // shifting into bit 0. It starts at a nonzero seed, so it never reaches
    // all-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 11'd18;
        end else begin
            r_lfsr <= {r_lfsr[9:0], r_lfsr[10] ^ r_lfsr[8]};
        end
    end

    assign w_raw6  = r_lfsr[2:0];
    assign w_raw20 = r_lfsr[4:0];

    // The final roll rejects out-of-range raw values instead of reducing
    // them, so no face is favoured.
    assign w_accept      = r_mode ? (w_raw20 < 5'd20) : (w_raw6 < 3'd6);
    assign w_sample_face = r_mode ? (w_raw20 + 5'd1) : ({2'b00, w_raw6} + 5'd1);

`ifdef DICE_ROLL_ANIM_EN
    // Animation faces only need to look random, so a cheap
    // conditional-subtract modulo is used here.
    assign w_mod6      = (w_raw6 >= 3'd6) ? (w_raw6 - 3'd6) : w_raw6;
    assign w_mod20     = (w_raw20 >= 5'd20) ? (w_raw20 - 5'd20) : w_raw20;
    assign w_anim_face = r_mode ? (w_mod20 + 5'd1) : ({2'b00, w_mod6} + 5'd1);
    assign w_frame_len = 16'(ANIM_BASE * (int'(r_frame) + 1));
`endif

    // Roll sequencer. A press arms the roll, and the release starts it.
    // Edges seen during ANIM/SAMPLE are ignored. A button still held when
    // SHOW is entered produces no edge, so it cannot start another roll.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_mode         <= 1'b0;
            r_dice_value   <= 5'd0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
`ifdef DICE_ROLL_ANIM_EN
            r_frame        <= '0;
            r_frame_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE, SHOW: begin
                    if (w_rise) begin
                        r_state        <= ARMED;
                        r_mode         <= twty_mode;
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b1;
                    end
                end
                ARMED: begin
                    if (w_fall) begin
`ifdef DICE_ROLL_ANIM_EN
                        r_state      <= ANIM;
                        r_frame      <= '0;
                        r_frame_cnt  <= '0;
                        r_dice_value <= w_anim_face;
`else
                        r_state <= SAMPLE;
`endif
                    end
                end
                ANIM: begin
`ifdef DICE_ROLL_ANIM_EN
                    if (r_frame_cnt == w_frame_len - 16'd1) begin
                        if (r_frame == 16'(ANIM_STEPS - 1)) begin
                            r_state <= SAMPLE;
                        end else begin
                            r_frame      <= r_frame + 16'd1;
                            r_frame_cnt  <= '0;
                            r_dice_value <= w_anim_face;
                        end
                    end else begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
`else
                    // Cannot be reached without the animation.
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
`endif
                end
                SAMPLE: begin
                    if (w_accept) begin
                        r_state        <= SHOW;
                        r_dice_value   <= w_sample_face;
                        r_result_valid <= 1'b1;
                        r_busy         <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dice_value   = r_dice_value;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dice_roll_ctrl
//
// Purpose:
//   Self-checking bench for dice_roll_ctrl with default parameters. A bench
//   LFSR model runs in lock-step with the clock. When a button release is
//   driven, the expected final face and the cycle it appears on are
//   predicted and pushed to a scoreboard. A negedge monitor pops the
//   scoreboard whenever result_valid rises.
//   Honours `DICE_ROLL_ANIM_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_dice_roll_ctrl;

    localparam int DB = 16;
    localparam int AB = 4;
    localparam int AS = 8;
`ifdef DICE_ROLL_ANIM_EN
    localparam int ANIM_LEN = AB * AS * (AS + 1) / 2;
`else
    localparam int ANIM_LEN = 0;
`endif
    // Press/release edge driven after edge E0: the sync takes 2 edges and
    // the debounce DB edges, so the level changes at E(DB+2). The edge
    // pulse acts one edge later.
    localparam int EDGE_LAT = DB + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       trigger;
    logic       twty_mode;
    logic [4:0] dice_value;
    logic       result_valid;
    logic       busy;

    dice_roll_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .trigger      (trigger),
        .twty_mode    (twty_mode),
        .dice_value   (dice_value),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] value;
        int         cycle;
        logic       mode;
    } exp_t;

    typedef struct {
        int   len;
        logic mode;
        logic expBusy;
    } vec_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [10:0] mLfsr;
    logic       prevValid = 1'b0;
    logic [4:0] prevDice = 5'd0;
    logic [4:0] lastFinal = 5'd0;
    bit         seen6 [0:7];
    bit         sawHigh20 = 1'b0;

    function automatic logic [10:0] lfsrNext(input logic [10:0] s);
        return {s[9:0], s[10] ^ s[8]};
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        mLfsr <= rst ? 11'd18 : lfsrNext(mLfsr);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Called on the negedge where the release is driven: mLfsr is L(0).
    // SAMPLE tests L(EDGE_LAT+ANIM_LEN) first and accepts one edge later.
    task automatic predictRoll(input logic mode);
        logic [10:0] s;
        logic [4:0]  raw;
        int          r;
        exp_t        e;
        s = mLfsr;
        for (int i = 0; i < EDGE_LAT + ANIM_LEN; i++) s = lfsrNext(s);
        r = 0;
        forever begin
            raw = mode ? s[4:0] : {2'b00, s[2:0]};
            if ((mode && raw < 5'd20) || (!mode && raw < 5'd6) || r > 64) break;
            s = lfsrNext(s);
            r++;
        end
        e.value = raw + 5'd1;
        e.cycle = cyc + EDGE_LAT + 1 + ANIM_LEN + r;
        e.mode  = mode;
        sbq.push_back(e);
    endtask

    task automatic waitRoll();
        int n = 0;
        while (sbq.size() != 0 && n < 400 + ANIM_LEN) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checkOutput("roll_timeout", 0, 1);
            sbq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic applyStimulus(input int hold, input logic mode, input logic toggleMode);
        @(negedge clk);
        twty_mode = mode;
        trigger   = 1'b1;
        repeat (hold) @(negedge clk);
        checkOutput("busy_armed", int'(busy), 1);
        checkOutput("valid_low_armed", int'(result_valid), 0);
        trigger = 1'b0;
        predictRoll(mode);
        if (toggleMode) begin
            repeat (3) @(negedge clk);
            twty_mode = ~mode;
        end
        waitRoll();
    endtask

    // Scoreboard monitor: every rising edge of result_valid must match the
    // oldest prediction, both in value and in cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            prevValid <= 1'b0;
            lastFinal <= 5'd0;
        end else begin
            if (result_valid && !prevValid) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_valid", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("final_value", int'(dice_value), int'(e.value));
                    checkOutput("final_cycle", cyc, e.cycle);
                    checkOutput("busy_at_result", int'(busy), 0);
                    if (e.mode) begin
                        checkOutput("d20_range", int'(dice_value >= 5'd1 && dice_value <= 5'd20), 1);
                        if (dice_value > 5'd6) sawHigh20 <= 1'b1;
                    end else begin
                        checkOutput("d6_range", int'(dice_value >= 5'd1 && dice_value <= 5'd6), 1);
                        checkOutput("d6_upper_bits", int'(dice_value[4:3]), 0);
                        if (dice_value <= 5'd6) seen6[dice_value[2:0]] <= 1'b1;
                    end
`ifndef DICE_ROLL_ANIM_EN
                    checkOutput("no_intermediate_value", int'(prevDice), int'(lastFinal));
`endif
                    lastFinal <= e.value;
                end
            end
            prevValid <= result_valid;
        end
        prevDice <= dice_value;
    end

    initial begin
        vec_t vecs [5];
        bit   sawBusy;
        bit   sawValid;
        int   hold;

        vecs[0] = '{len: 3,  mode: 1'b0, expBusy: 1'b0};
        vecs[1] = '{len: 10, mode: 1'b0, expBusy: 1'b0};
        vecs[2] = '{len: 15, mode: 1'b1, expBusy: 1'b0};
        vecs[3] = '{len: 16, mode: 1'b0, expBusy: 1'b1};
        vecs[4] = '{len: 10, mode: 1'b1, expBusy: 1'b0};

        rst       = 1'b1;
        trigger   = 1'b0;
        twty_mode = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("lfsr_reset", int'(dut.r_lfsr), 18);
        checkOutput("reset_dice", int'(dice_value), 0);
        checkOutput("reset_valid", int'(result_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        rst = 1'b0;

        repeat (100) @(negedge clk);
        checkOutput("idle_dice", int'(dice_value), 0);
        checkOutput("idle_valid", int'(result_valid), 0);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("lfsr_model", int'(dut.r_lfsr), int'(mLfsr));

        // Pulse-length table around the debounce boundary.
        foreach (vecs[i]) begin
            @(negedge clk);
            twty_mode = vecs[i].mode;
            trigger   = 1'b1;
            repeat (vecs[i].len) @(negedge clk);
            trigger = 1'b0;
            if (vecs[i].expBusy) predictRoll(vecs[i].mode);
            sawBusy = 1'b0;
            repeat (30) begin
                @(negedge clk);
                sawBusy |= busy;
            end
            checkOutput($sformatf("pulse_busy_len%0d", vecs[i].len), int'(sawBusy), int'(vecs[i].expBusy));
            waitRoll();
            repeat (5) @(negedge clk);
        end

        // d6 rolls with varied press lengths.
        for (int n = 0; n < 60; n++) begin
            hold = int'($urandom_range(20, 50));
            applyStimulus(hold, 1'b0, 1'b0);
        end
        for (int f = 1; f <= 6; f++) checkOutput($sformatf("face_seen_%0d", f), int'(seen6[f]), 1);

        // d20 rolls; mode flipped after the latch point has no effect.
        for (int n = 0; n < 40; n++) begin
            hold = int'($urandom_range(20, 50));
            applyStimulus(hold, 1'b1, 1'b1);
        end
        checkOutput("d20_above_6_seen", int'(sawHigh20), 1);

        // Reset pulse on the first SAMPLE cycle aborts the roll.
        @(negedge clk);
        twty_mode = 1'b0;
        trigger   = 1'b1;
        repeat (30) @(negedge clk);
        trigger = 1'b0;
        repeat (EDGE_LAT + ANIM_LEN) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_dice", int'(dice_value), 0);
        checkOutput("abort_valid", int'(result_valid), 0);
        checkOutput("abort_busy", int'(busy), 0);
        rst = 1'b0;
        sawValid = 1'b0;
        repeat (60) begin
            @(negedge clk);
            sawValid |= result_valid;
        end
        checkOutput("abort_no_valid", int'(sawValid), 0);

        // A clean roll after the abort starts from dice_value 0.
        applyStimulus(25, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
